// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide issue controller:
// HI/LO op codes, unit strobe encodings and default unit latencies.
package md_pkg;

  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MFHI  = 4'd7;
  localparam logic [3:0] MD_OP_MFLO  = 4'd8;

  localparam logic [1:0] MD_TYPE_MULT  = 2'b00;
  localparam logic [1:0] MD_TYPE_MULTU = 2'b01;
  localparam logic [1:0] MD_TYPE_DIV   = 2'b10;
  localparam logic [1:0] MD_TYPE_DIVU  = 2'b11;

  localparam logic [1:0] MD_WRITE_NONE = 2'b00;
  localparam logic [1:0] MD_WRITE_HI   = 2'b01;
  localparam logic [1:0] MD_WRITE_LO   = 2'b10;

  localparam logic [1:0] MD_RDSEL_NONE = 2'b00;
  localparam logic [1:0] MD_RDSEL_HI   = 2'b01;
  localparam logic [1:0] MD_RDSEL_LO   = 2'b10;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MRUN = 2'd1,
    MD_DRUN = 2'd2
  } mdStateE;

  // Ops that occupy the unit (start or HI/LO write) and are illegal mid-run.
  function automatic logic isUnitOp(input logic [3:0] op);
    return (op >= MD_OP_MULT) && (op <= MD_OP_MTLO);
  endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// Loadable 4-bit down-counter that tracks the remaining busy cycles of the
// multiply/divide unit and flags the final busy cycle.
module md_latency_cnt
  import md_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] loadValue,
  output logic [3:0] count,
  output logic       lastCycle
);

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign lastCycle = (count == 4'd1);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the E-stage multiply/divide unit: decodes
// HI/LO ops, strobes the unit, tracks its latency and stalls D-stage consumers.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       E_Valid,
  input  logic [3:0] E_MD_Op,
  input  logic       D_MD_Use,
  output logic       MD_Start,
  output logic [1:0] MD_Type,
  output logic [1:0] MD_Write,
  output logic [1:0] MD_RdSel,
  output logic       Stall_D,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  mdStateE    state;
  logic       opValid;
  logic       inRun;
  logic       isMulOp;
  logic       isDivOp;
  logic       issue;
  logic       violation;
  logic [3:0] loadValue;
  logic [3:0] count;
  logic       lastCycle;

  assign opValid   = E_Valid && !Reset;
  assign inRun     = (state != MD_IDLE);
  assign isMulOp   = (E_MD_Op == MD_OP_MULT) || (E_MD_Op == MD_OP_MULTU);
  assign isDivOp   = (E_MD_Op == MD_OP_DIV)  || (E_MD_Op == MD_OP_DIVU);
  assign issue     = opValid && !inRun && (isMulOp || isDivOp);
  assign violation = opValid && inRun && isUnitOp(E_MD_Op);
  assign loadValue = isMulOp ? MULT_LOAD : DIV_LOAD;

  md_latency_cnt uLatencyCnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (issue),
    .loadValue(loadValue),
    .count    (count),
    .lastCycle(lastCycle)
  );

  // Decode of the E-stage op into unit strobes; everything is gated by opValid
  // so bubbles and reset cycles never reach the unit.
  always_comb begin
    MD_Start = issue;
    MD_Type  = MD_TYPE_MULT;
    MD_Write = MD_WRITE_NONE;
    MD_RdSel = MD_RDSEL_NONE;
    if (issue) begin
      case (E_MD_Op)
        MD_OP_MULTU: MD_Type = MD_TYPE_MULTU;
        MD_OP_DIV:   MD_Type = MD_TYPE_DIV;
        MD_OP_DIVU:  MD_Type = MD_TYPE_DIVU;
        default:     MD_Type = MD_TYPE_MULT;
      endcase
    end
    if (opValid && !inRun) begin
      if (E_MD_Op == MD_OP_MTHI) MD_Write = MD_WRITE_HI;
      if (E_MD_Op == MD_OP_MTLO) MD_Write = MD_WRITE_LO;
    end
    if (opValid) begin
      if (E_MD_Op == MD_OP_MFHI) MD_RdSel = MD_RDSEL_HI;
      if (E_MD_Op == MD_OP_MFLO) MD_RdSel = MD_RDSEL_LO;
    end
  end

  assign Stall_D = D_MD_Use && (MD_Start || Busy) && !Reset;

  // Run-state FSM. Done is registered one cycle ahead: it is set on the edge
  // that leaves the counter at 1, so it lines up with the last busy cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= MD_IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      if (violation) Err <= 1'b1;
      case (state)
        MD_IDLE: begin
          if (issue) begin
            state <= isMulOp ? MD_MRUN : MD_DRUN;
            Busy  <= 1'b1;
            Done  <= (loadValue == 4'd1);
          end else begin
            Busy <= 1'b0;
            Done <= 1'b0;
          end
        end
        MD_MRUN, MD_DRUN: begin
          if (lastCycle) begin
            state <= MD_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
          end else begin
            Busy <= 1'b1;
            Done <= (count == 4'd2);
          end
        end
        default: begin
          state <= MD_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: each driven cycle pushes the expected
// outputs from a cycle-level model, which are popped and compared mid-cycle.
module tb_md_issue_ctrl;

  logic       Clk;
  logic       Reset;
  logic       E_Valid;
  logic [3:0] E_MD_Op;
  logic       D_MD_Use;
  logic       MD_Start;
  logic [1:0] MD_Type;
  logic [1:0] MD_Write;
  logic [1:0] MD_RdSel;
  logic       Stall_D;
  logic       Busy;
  logic       Done;
  logic       Err;

  typedef struct {
    logic       start;
    logic [1:0] mdType;
    logic [1:0] write;
    logic [1:0] rdSel;
    logic       stall;
    logic       busy;
    logic       done;
    logic       err;
  } expectT;

  expectT expectQ[$];
  int     checkCount = 0;
  int     errorCount = 0;
  int     busyLeft   = 0;
  logic   modelErr   = 1'b0;
  int     cycleNum   = 0;

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .E_Valid (E_Valid),
    .E_MD_Op (E_MD_Op),
    .D_MD_Use(D_MD_Use),
    .MD_Start(MD_Start),
    .MD_Type (MD_Type),
    .MD_Write(MD_Write),
    .MD_RdSel(MD_RdSel),
    .Stall_D (Stall_D),
    .Busy    (Busy),
    .Done    (Done),
    .Err     (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", tag, cycleNum, observed, expected);
    end
  endtask

  task automatic compareScoreboard();
    expectT e;
    if (expectQ.size() == 0) begin
      checkOutput("queueEmpty", 2'd1, 2'd0);
      return;
    end
    e = expectQ.pop_front();
    checkOutput("MD_Start", {1'b0, MD_Start}, {1'b0, e.start});
    checkOutput("MD_Type",  MD_Type,  e.mdType);
    checkOutput("MD_Write", MD_Write, e.write);
    checkOutput("MD_RdSel", MD_RdSel, e.rdSel);
    checkOutput("Stall_D",  {1'b0, Stall_D}, {1'b0, e.stall});
    checkOutput("Busy",     {1'b0, Busy},    {1'b0, e.busy});
    checkOutput("Done",     {1'b0, Done},    {1'b0, e.done});
    checkOutput("Err",      {1'b0, Err},     {1'b0, e.err});
  endtask

  // One clock cycle: drive, predict, compare at negedge, then advance the model.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] op, input logic u);
    expectT e;
    logic   valid, isStart, isWr, busyNow;
    Reset    = r;
    E_Valid  = v;
    E_MD_Op  = op;
    D_MD_Use = u;
    valid    = v && !r;
    isStart  = (op >= 4'd1) && (op <= 4'd4);
    isWr     = (op == 4'd5) || (op == 4'd6);
    busyNow  = (busyLeft > 0);
    e.start  = valid && !busyNow && isStart;
    e.mdType = e.start ? 2'(op - 4'd1) : 2'b00;
    e.write  = (valid && !busyNow && isWr) ? ((op == 4'd5) ? 2'b01 : 2'b10) : 2'b00;
    e.rdSel  = (valid && op == 4'd7) ? 2'b01 : (valid && op == 4'd8) ? 2'b10 : 2'b00;
    e.stall  = !r && u && (e.start || busyNow);
    e.busy   = busyNow;
    e.done   = (busyLeft == 1);
    e.err    = modelErr;
    expectQ.push_back(e);
    @(negedge Clk);
    compareScoreboard();
    @(posedge Clk);
    #1;
    cycleNum++;
    if (r) begin
      busyLeft = 0;
      modelErr = 1'b0;
    end else begin
      if (valid && busyNow && (isStart || isWr)) modelErr = 1'b1;
      if (e.start) busyLeft = (op <= 4'd2) ? 5 : 10;
      else if (busyLeft > 0) busyLeft--;
    end
  endtask

  task automatic idleCycles(input int n, input logic u);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, u);
  endtask

  initial begin
    Reset = 1'b1; E_Valid = 1'b0; E_MD_Op = 4'd0; D_MD_Use = 1'b0;
    @(posedge Clk);
    #1;
    // Reset cycles, including a live op that must stay gated.
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b1);
    idleCycles(1, 1'b0);
    // mult with a HI/LO consumer waiting in D.
    applyStimulus(1'b0, 1'b1, 4'd1, 1'b1);
    idleCycles(6, 1'b1);
    // divu, consumer absent, mthi violation at cycle 2.
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b0);
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
    idleCycles(9, 1'b0);
    // mflo valid / invalid, mthi / mtlo in idle, undefined op.
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd8, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd6, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd12, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    // div interrupted by reset at cycle 3, then a clean mult.
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b1);
    idleCycles(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b1);
    idleCycles(3, 1'b1);
    // Issue attempt on the Done cycle is a violation; the next cycle issues.
    applyStimulus(1'b0, 1'b1, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b1);
    idleCycles(11, 1'b0);
    if (expectQ.size() != 0) checkOutput("queueLeft", 2'(expectQ.size()), 2'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Sequencing controller for the E-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Decodes the E-stage HI/LO operation and issues a one-cycle start or write strobe to the unit.
- Tracks the unit's fixed latency with its own countdown and raises the D-stage stall while a HI/LO consumer would see stale data.
- Latches a sticky error if a new HI/LO operation reaches E while the unit is running.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start; legal range 1..15.
- DIV_CYCLES, 10, busy cycles after a div/divu start; legal range 1..15.

Ports:
- Clk  input  1  clock.
- Reset  input  1  synchronous, active-high reset.
- E_Valid  input  1  E-stage slot holds a real, non-bubble instruction.
- E_MD_Op  input  4  E-stage HI/LO op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9..15 treated as none.
- D_MD_Use  input  1  D-stage instruction is any of codes 1..8.
- MD_Start  output  1  one-cycle start strobe to the unit.
- MD_Type  output  2  operation type: 00 mult, 01 multu, 10 div, 11 divu; 00 when MD_Start=0.
- MD_Write  output  2  01 mthi, 10 mtlo, 00 otherwise.
- MD_RdSel  output  2  E result select: 01 HI (mfhi), 10 LO (mflo), 00 none.
- Stall_D  output  1  freeze the F/D stages and insert a bubble into E.
- Busy  output  1  unit is computing.
- Done  output  1  one-cycle pulse on the last busy cycle.
- Err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset values: state IDLE, counter 0, Busy 0, Done 0, Err 0. All registered state clears at the next edge while Reset=1.
- While Reset=1, every combinational output is 0, including MD_Start, MD_Write, MD_RdSel and Stall_D.
- States and transitions:
  - IDLE -> MRUN when E_Valid and E_MD_Op is 1 or 2 (mult/multu).
  - IDLE -> DRUN when E_Valid and E_MD_Op is 3 or 4 (div/divu).
  - MRUN/DRUN -> IDLE when the counter reaches 1 at an edge.
- Issue cycle (cycle 0):
  - In IDLE, a mult/div op drives MD_Start=1 combinationally with the matching MD_Type.
  - At that edge the counter loads MULT_CYCLES or DIV_CYCLES, as selected by the op.
- Run cycles: Busy=1 throughout MRUN/DRUN, i.e. cycles 1..N after issue. The counter decrements each edge.
- Done: pulses 1 while the counter is 1 in a RUN state, i.e. on cycle N.
- Result timing: the unit's HI/LO hold the result from cycle N+1.
- Stall rule: Stall_D = D_MD_Use and (MD_Start or Busy) and not Reset.
  - A HI/LO consumer in D therefore enters E at cycle N+1 at the earliest.
  - Stall_D does not depend on Done.
- mthi/mtlo (codes 5, 6) with E_Valid in IDLE: MD_Write=01 or 10 for exactly that cycle. No state change.
- mfhi/mflo (codes 7, 8) with E_Valid: MD_RdSel=01 or 10. This is purely combinational and is driven in any state.
- Protocol violation:
  - Trigger: E_Valid and E_MD_Op in 1..6 while in MRUN/DRUN.
  - Response: the op is ignored, with no MD_Start and no MD_Write; Err is set at the edge and stays set until Reset. The running countdown is unaffected.
- Mid-op: Reset mid-operation returns to IDLE at the next edge, drops Busy and emits no Done.
- E_Valid=0 suppresses every decode output regardless of E_MD_Op.
- Back-to-back ops: a new mult/div may issue at cycle N+1 (IDLE again). There is no combined done-and-issue cycle.

Decomposition:
- Shared package md_pkg holds:
  - MD op codes 0..8.
  - MD_Type encodings: mult, multu, div, divu.
  - MD_Write encodings: mthi, mtlo.
  - MD_RdSel encodings.
  - Default MULT_CYCLES/DIV_CYCLES.
- Optional sub-module md_latency_cnt: loadable 4-bit down-counter with a last-cycle flag. The FSM and decode stay in the top module.

Test Plan:
- Reset for 2 cycles, then idle: Busy=0, Done=0, Err=0, all strobes 0.
- mult issued at cycle 0 with D_MD_Use=1:
  - MD_Start=1, MD_Type=00 at cycle 0.
  - Busy=1 at cycles 1..5; Done at cycle 5.
  - Stall_D=1 at cycles 0..5 and 0 at cycle 6.
- divu issued at cycle 0: MD_Type=11, Busy at cycles 1..10, Done at cycle 10.
- D_MD_Use=0 during a run: Stall_D=0 throughout. mthi with E_Valid at cycle 2 of the run: MD_Write=00 and Err=1 from cycle 3 on.
- mflo with E_Valid while idle: MD_RdSel=10, Stall_D=0. The same op with E_Valid=0 gives MD_RdSel=00.
- Reset asserted at cycle 3 of a div: Busy=0 from the next cycle, no Done pulse. A following mult then issues normally, with Busy for exactly 5 cycles.
